priority_encoder_drain: RTL and testbench
=========================================

Name: priority_encoder_drain

Overview:
Sequential, parametrised successor to the combinational priority encoder. It accepts a request vector through a valid/ready handshake and latches it. It then emits the index of every set bit, one per accepted output beat, in priority order. It sits between interrupt/request collectors and single-issue consumers that must service every pending request, not only the highest one.

Parameters:
N, 8, request vector width; legal range N >= 2, power of two not required
LSB_FIRST, 0, 0 = highest set index served first (MSB priority); 1 = lowest set index first
W, $clog2(N), index width; derived localparam, not overridable

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort; discards pending bits
in_valid  input  1  request vector valid
in_ready  output  1  block can accept a vector
in_vec  input  N  request vector
out_valid  output  1  out_idx valid
out_ready  input  1  consumer accepts current index
out_idx  output  W  index of current highest-priority pending bit
out_last  output  1  current index is the final pending bit of the vector
zero_drop  output  1  one-cycle pulse: an all-zero vector was accepted and discarded

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, pending=0, out_valid=0, out_idx=0, out_last=0, zero_drop=0, in_ready=1.
- States: IDLE, DRAIN. in_ready = (state==IDLE). out_valid = (state==DRAIN).
- IDLE, in_valid && in_ready at edge k:
  - in_vec != 0: pending <= in_vec, go to DRAIN. out_valid is first high in cycle k+1 (1-cycle latency).
  - in_vec == 0: stay in IDLE, zero_drop=1 for cycle k+1 only.
- DRAIN outputs are registered, or combinational from the registered pending vector; either way there is no combinational path from in_* to out_*:
  - out_idx = index of highest set bit of pending (LSB_FIRST=0) or lowest set bit (LSB_FIRST=1).
  - out_last = exactly one bit set in pending.
- DRAIN, out_valid && out_ready: clear bit out_idx in pending. If out_last, go to IDLE, so in_ready=1 in the next cycle. Otherwise stay in DRAIN; the next index is presented in the next cycle.
- Back-pressure: while out_ready=0, out_idx and out_last hold stable.
- No overlap: a new vector is not accepted until the final beat of the current vector has been taken. Peak throughput is one index per cycle, plus one idle cycle between vectors.
- flush=1 at an edge: pending <= 0, state <= IDLE, no zero_drop pulse.
  - flush has priority over simultaneous input and output handshakes in the same cycle. The accepted index still counts as delivered, but no further indices are emitted.
- out_idx is never >= N for non-power-of-two N. Unused index codes never appear.
- Reset asserted mid-DRAIN: all state cleared immediately; no partial beat.

Optional Feature:
Macro PENC_COUNT_EN.
- Defined: adds output port out_remaining, width W+1 = popcount(pending), the number of indices still to deliver including the current one. Reset value 0; 0 in IDLE; decrements by 1 on each output handshake.
- Undefined: port and popcount logic absent; all other behaviour identical.

Test Plan:
- N=8, LSB_FIRST=0, out_ready=1; in_vec=8'b1010_0101 -> out_idx 7,5,2,0 on four consecutive cycles; out_last only with 0; in_ready high again the cycle after.
- Same vector with LSB_FIRST=1 -> order 0,2,5,7.
- in_vec=8'h00 accepted -> no out_valid; zero_drop high exactly one cycle; in_ready stays 1.
- in_vec=8'h81; hold out_ready=0 for 3 cycles -> out_idx=7 stable and in_ready=0 throughout; release -> 7 then 0 with out_last.
- in_vec=8'hFF; after 2 beats assert flush together with out_ready -> state IDLE next cycle, out_valid=0, in_ready=1. With PENC_COUNT_EN, out_remaining reads 8,7,6 and then 0.
- N=5, in_vec=5'b10011 -> out_idx 4,1,0 (W=3). Assert rst_n low mid-drain -> out_valid=0 immediately and no further indices.

Source files
------------

// File: rtl/priority_encoder_drain_if.sv
// rtl/priority_encoder_drain_if.sv - handshake bundle for priority_encoder_drain; PENC_COUNT_EN adds out_remaining
interface priority_encoder_drain_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic         zero_drop;
`ifdef PENC_COUNT_EN
    logic [W:0]   out_remaining;
`endif

    // Block side
    modport slave (
`ifdef PENC_COUNT_EN
        output out_remaining,
`endif
        input  flush, in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, zero_drop
    );

    // Producer/consumer side
    modport master (
`ifdef PENC_COUNT_EN
        input  out_remaining,
`endif
        output flush, in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, zero_drop
    );
endinterface

// File: rtl/priority_encoder_drain.sv
// rtl/priority_encoder_drain.sv - latches a request vector and emits each set index in priority order; PENC_COUNT_EN adds out_remaining
module priority_encoder_drain #(
    parameter int N         = 8,
    parameter int LSB_FIRST = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    priority_encoder_drain_if.slave  bus
);
    localparam int W = $clog2(N);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] pending;
    logic [N-1:0] clr_mask;
    logic [W-1:0] enc_idx;
    logic         one_left;
    logic         zero_drop_q;
    logic         in_acc;
    logic         out_acc;

    assign in_acc  = bus.in_valid && (state == IDLE);
    assign out_acc = bus.out_ready && (state == DRAIN);

    // Priority-encode the pending vector; only real bit positions can win,
    // so codes >= N never appear for non-power-of-two widths.
    always_comb begin
        enc_idx = '0;
        if (LSB_FIRST != 0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (pending[i]) enc_idx = W'(i);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (pending[i]) enc_idx = W'(i);
            end
        end
        one_left = (pending != '0) && ((pending & (pending - ONE)) == '0);
        clr_mask = ONE << enc_idx;
    end

    // Next-state logic; flush wins over both handshakes
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.in_valid && (bus.in_vec != '0)) state_nxt = DRAIN;
                DRAIN:   if (bus.out_ready && one_left) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Pending vector: load on accept, retire the presented bit on each beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          pending <= '0;
        else if (bus.flush)  pending <= '0;
        else if (in_acc)     pending <= bus.in_vec;
        else if (out_acc)    pending <= pending & ~clr_mask;
    end

    // One-cycle pulse when an empty vector is swallowed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) zero_drop_q <= 1'b0;
        else        zero_drop_q <= !bus.flush && in_acc && (bus.in_vec == '0);
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DRAIN);
    assign bus.out_idx   = enc_idx;
    assign bus.out_last  = (state == DRAIN) && one_left;
    assign bus.zero_drop = zero_drop_q;

`ifdef PENC_COUNT_EN
    logic [W:0] pop;

    // Population count of what is still owed, current index included
    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + (W + 1)'(pending[i]);
        end
    end

    assign bus.out_remaining = pop;
`endif
endmodule

// File: tb/tb_priority_encoder_drain.sv
// tb/tb_priority_encoder_drain.sv - directed table-driven bench for priority_encoder_drain
module tb_priority_encoder_drain;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic       flush;
    logic [7:0] vec;
    int         sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    priority_encoder_drain_if #(.N(8)) ifa ();
    priority_encoder_drain_if #(.N(8)) ifb ();
    priority_encoder_drain_if #(.N(5)) ifc ();

    priority_encoder_drain #(.N(8), .LSB_FIRST(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    priority_encoder_drain #(.N(8), .LSB_FIRST(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    priority_encoder_drain #(.N(5), .LSB_FIRST(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    assign ifa.in_valid  = in_valid && (sel == 0);
    assign ifb.in_valid  = in_valid && (sel == 1);
    assign ifc.in_valid  = in_valid && (sel == 2);
    assign ifa.in_vec    = vec;
    assign ifb.in_vec    = vec;
    assign ifc.in_vec    = vec[4:0];
    assign ifa.out_ready = out_ready;
    assign ifb.out_ready = out_ready;
    assign ifc.out_ready = out_ready;
    assign ifa.flush     = flush;
    assign ifb.flush     = flush;
    assign ifc.flush     = flush;

    logic       m_valid, m_last, m_ready, m_zd;
    logic [2:0] m_idx;
    logic [3:0] m_rem;

    always_comb begin
        m_rem = '0;
        case (sel)
            0: begin
                m_valid = ifa.out_valid; m_last = ifa.out_last; m_ready = ifa.in_ready;
                m_zd = ifa.zero_drop; m_idx = ifa.out_idx;
`ifdef PENC_COUNT_EN
                m_rem = ifa.out_remaining;
`endif
            end
            1: begin
                m_valid = ifb.out_valid; m_last = ifb.out_last; m_ready = ifb.in_ready;
                m_zd = ifb.zero_drop; m_idx = ifb.out_idx;
`ifdef PENC_COUNT_EN
                m_rem = ifb.out_remaining;
`endif
            end
            default: begin
                m_valid = ifc.out_valid; m_last = ifc.out_last; m_ready = ifc.in_ready;
                m_zd = ifc.zero_drop; m_idx = ifc.out_idx;
`ifdef PENC_COUNT_EN
                m_rem = ifc.out_remaining;
`endif
            end
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rem(input string name, input int exp);
`ifdef PENC_COUNT_EN
        chk(name, int'(m_rem), exp);
`else
        if (exp < 0) $display("unused %s", name);
`endif
    endtask

    typedef struct {
        int         sel;
        logic [7:0] vec;
        int         n;
        int         idx[8];
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{sel: 0, vec: 8'hA5, n: 4, idx: '{7, 5, 2, 0, 0, 0, 0, 0}};
        tbl[1] = '{sel: 1, vec: 8'hA5, n: 4, idx: '{0, 2, 5, 7, 0, 0, 0, 0}};
        tbl[2] = '{sel: 0, vec: 8'h00, n: 0, idx: '{0, 0, 0, 0, 0, 0, 0, 0}};
        tbl[3] = '{sel: 2, vec: 8'h13, n: 3, idx: '{4, 1, 0, 0, 0, 0, 0, 0}};
        tbl[4] = '{sel: 1, vec: 8'h80, n: 1, idx: '{7, 0, 0, 0, 0, 0, 0, 0}};
        tbl[5] = '{sel: 2, vec: 8'h1F, n: 5, idx: '{4, 3, 2, 1, 0, 0, 0, 0}};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; vec = '0; sel = 0;
        @(negedge clk);
        chk("rst_valid", m_valid, 0);
        chk("rst_ready", m_ready, 1);
        chk("rst_idx", m_idx, 0);
        chk("rst_last", m_last, 0);
        chk("rst_zd", m_zd, 0);
        chk_rem("rst_rem", 0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int t = 0; t < 6; t++) begin
            sel = tbl[t].sel; vec = tbl[t].vec; in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1 in_valid = 1'b0;
            if (tbl[t].n == 0) begin
                @(negedge clk);
                chk($sformatf("t%0d_zd", t), m_zd, 1);
                chk($sformatf("t%0d_novalid", t), m_valid, 0);
                chk($sformatf("t%0d_ready", t), m_ready, 1);
                @(negedge clk);
                chk($sformatf("t%0d_zd_off", t), m_zd, 0);
            end else begin
                for (int j = 0; j < tbl[t].n; j++) begin
                    @(negedge clk);
                    chk($sformatf("t%0d_b%0d_valid", t, j), m_valid, 1);
                    chk($sformatf("t%0d_b%0d_idx", t, j), m_idx, tbl[t].idx[j]);
                    chk($sformatf("t%0d_b%0d_last", t, j), m_last, (j == tbl[t].n - 1) ? 1 : 0);
                    chk($sformatf("t%0d_b%0d_ready", t, j), m_ready, 0);
                    chk_rem($sformatf("t%0d_b%0d_rem", t, j), tbl[t].n - j);
                    @(posedge clk); #1;
                end
                @(negedge clk);
                chk($sformatf("t%0d_end_valid", t), m_valid, 0);
                chk($sformatf("t%0d_end_ready", t), m_ready, 1);
                chk_rem($sformatf("t%0d_end_rem", t), 0);
            end
        end

        // Back-pressure with a competing vector offered during the stall
        sel = 0; vec = 8'h81; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1 vec = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", k), m_valid, 1);
            chk($sformatf("bp%0d_idx", k), m_idx, 7);
            chk($sformatf("bp%0d_last", k), m_last, 0);
            chk($sformatf("bp%0d_ready", k), m_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_idx", m_idx, 7);
        chk("bp_rel_last", m_last, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_fin_idx", m_idx, 0);
        chk("bp_fin_last", m_last, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_end_valid", m_valid, 0);
        chk("bp_end_ready", m_ready, 1);

        // Flush after two beats, together with an output handshake
        sel = 0; vec = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk); chk("fl_b0_idx", m_idx, 7); chk_rem("fl_b0_rem", 8);
        @(posedge clk); #1;
        @(negedge clk); chk("fl_b1_idx", m_idx, 6); chk_rem("fl_b1_rem", 7);
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk); chk("fl_b2_idx", m_idx, 5); chk_rem("fl_b2_rem", 6);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("fl_valid", m_valid, 0);
        chk("fl_ready", m_ready, 1);
        chk("fl_zd", m_zd, 0);
        chk_rem("fl_rem", 0);

        // Flush beats a simultaneous input handshake
        vec = 8'h03; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flin_valid", m_valid, 0);
        chk("flin_ready", m_ready, 1);
        chk("flin_zd", m_zd, 0);

        // Asynchronous reset in the middle of a drain on the N=5 block
        sel = 2; vec = 8'h13; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk); chk("rs_b0_idx", m_idx, 4);
        @(posedge clk); #1;
        @(negedge clk); chk("rs_b1_idx", m_idx, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_valid", m_valid, 0);
        chk("rs_idx", m_idx, 0);
        chk("rs_last", m_last, 0);
        chk("rs_ready", m_ready, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("rs_after%0d_valid", k), m_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
